// File: rtl/alarm_pkg.sv
// Shared alarm controller types: state encoding and default timing constants.
package alarm_pkg;

   typedef enum logic [1:0] {
      StOff     = 2'b00,
      StArmed   = 2'b01,
      StRinging = 2'b10,
      StSnooze  = 2'b11
   } alarm_state_e;

   localparam int unsigned RING_SEC_DEF   = 60;
   localparam int unsigned SNOOZE_SEC_DEF = 300;
   localparam int unsigned MAX_SNOOZE_DEF = 3;

   localparam logic [4:0] HR_MAX  = 5'd23;
   localparam logic [5:0] MIN_MAX = 6'd59;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/alarm_timer.sv
// Seconds down-counter shared by the ringing and snooze phases.
module alarm_timer #(
   parameter int unsigned W = 9
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   input  logic         i_sec_tick,
   output logic         o_done
);

   logic [W-1:0] r_cnt;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= i_load_val;
      end else if (i_sec_tick && (r_cnt != '0)) begin
         r_cnt <= r_cnt - 1'b1;
      end
   end

   // Pulses on the tick that expires the interval, so the owner can leave on that edge.
   assign o_done = i_sec_tick && (r_cnt == W'(1));

endmodule

// File: rtl/alarm_ctrl.sv
// Alarm clock controller: alarm-time setting, arm/ring/snooze FSM and buzzer drive.
module alarm_ctrl
   import alarm_pkg::*;
#(
   parameter int unsigned RING_SEC   = RING_SEC_DEF,
   parameter int unsigned SNOOZE_SEC = SNOOZE_SEC_DEF,
   parameter int unsigned MAX_SNOOZE = MAX_SNOOZE_DEF
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_sec_tick,
   input  logic [4:0] i_cur_hr,
   input  logic [5:0] i_cur_min,
   input  logic [5:0] i_cur_sec,
   input  logic       i_alarm_on,
   input  logic       i_set_en,
   input  logic       i_hr_or_min,
   input  logic       i_inc,
   input  logic       i_stop,
   input  logic       i_snooze,
   output logic [4:0] o_al_hr,
   output logic [5:0] o_al_min,
   output logic [1:0] o_state,
   output logic       o_ringing,
   output logic       o_snoozing,
   output logic       o_buzz
);

   localparam int unsigned TimerW = $clog2(max_u(RING_SEC, SNOOZE_SEC) + 1);
   localparam int unsigned SnzW   = $clog2(MAX_SNOOZE + 1) > 0 ? $clog2(MAX_SNOOZE + 1) : 1;

   alarm_state_e      r_state, w_state_d;
   logic [SnzW-1:0]   r_snz_cnt, w_snz_cnt_d;
   logic              r_beep, w_beep_d;
   logic [4:0]        r_al_hr;
   logic [5:0]        r_al_min;
   logic              w_match;
   logic              w_timer_tick;
   logic              w_timer_load;
   logic [TimerW-1:0] w_timer_val;
   logic              w_timer_done;

   assign w_match = i_sec_tick && !i_set_en && (i_cur_hr == r_al_hr) &&
                    (i_cur_min == r_al_min) && (i_cur_sec == 6'd0);

   assign w_timer_tick = i_sec_tick && ((r_state == StRinging) || (r_state == StSnooze));
   assign w_timer_load = (w_state_d != r_state);

   always_comb begin
      w_timer_val = '0;
      if (w_state_d == StRinging) begin
         w_timer_val = TimerW'(RING_SEC);
      end else if (w_state_d == StSnooze) begin
         w_timer_val = TimerW'(SNOOZE_SEC);
      end
   end

   alarm_timer #(
      .W (TimerW)
   ) u_timer (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_load     (w_timer_load),
      .i_load_val (w_timer_val),
      .i_sec_tick (w_timer_tick),
      .o_done     (w_timer_done)
   );

   always_comb begin
      w_state_d   = r_state;
      w_snz_cnt_d = r_snz_cnt;
      if (!i_alarm_on) begin
         w_state_d = StOff;
      end else begin
         unique case (r_state)
            StOff:   w_state_d = StArmed;
            StArmed: if (w_match) w_state_d = StRinging;
            StRinging: begin
               if (i_stop) begin
                  w_state_d = StArmed;
               end else if (i_snooze) begin
                  // Once the snooze allowance is spent, snooze behaves like stop.
                  if (r_snz_cnt < SnzW'(MAX_SNOOZE)) begin
                     w_state_d   = StSnooze;
                     w_snz_cnt_d = r_snz_cnt + 1'b1;
                  end else begin
                     w_state_d = StArmed;
                  end
               end else if (w_timer_done) begin
                  w_state_d = StArmed;
               end
            end
            StSnooze: begin
               if (i_stop) begin
                  w_state_d = StArmed;
               end else if (w_timer_done) begin
                  w_state_d = StRinging;
               end
            end
            default: w_state_d = StOff;
         endcase
      end
      if ((w_state_d == StOff) || (w_state_d == StArmed)) begin
         w_snz_cnt_d = '0;
      end
   end

   always_comb begin
      w_beep_d = 1'b0;
      if (w_state_d == StRinging) begin
         if (r_state != StRinging) begin
            w_beep_d = 1'b1;
         end else if (i_sec_tick) begin
            w_beep_d = ~r_beep;
         end else begin
            w_beep_d = r_beep;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state   <= StOff;
         r_snz_cnt <= '0;
         r_beep    <= 1'b0;
      end else begin
         r_state   <= w_state_d;
         r_snz_cnt <= w_snz_cnt_d;
         r_beep    <= w_beep_d;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_al_hr  <= '0;
         r_al_min <= '0;
      end else if (i_set_en && i_inc) begin
         if (i_hr_or_min) begin
            r_al_min <= (r_al_min == MIN_MAX) ? '0 : r_al_min + 1'b1;
         end else begin
            r_al_hr <= (r_al_hr == HR_MAX) ? '0 : r_al_hr + 1'b1;
         end
      end
   end

   assign o_al_hr    = r_al_hr;
   assign o_al_min   = r_al_min;
   assign o_state    = r_state;
   assign o_ringing  = (r_state == StRinging);
   assign o_snoozing = (r_state == StSnooze);
   assign o_buzz     = r_beep;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Self-checking bench for alarm_ctrl: directed scenarios plus randomized run against a model.
module tb_alarm_ctrl;

   localparam int RING = 60;
   localparam int SNZ  = 300;
   localparam int MAXS = 3;

   localparam logic [1:0] S_OFF = 2'b00;
   localparam logic [1:0] S_ARM = 2'b01;
   localparam logic [1:0] S_RNG = 2'b10;
   localparam logic [1:0] S_SNZ = 2'b11;

   logic       clk = 1'b0;
   logic       rst, sec_tick, alarm_on, set_en, hr_or_min, inc, stop, snooze;
   logic [4:0] cur_hr;
   logic [5:0] cur_min, cur_sec;
   logic [4:0] al_hr;
   logic [5:0] al_min;
   logic [1:0] state;
   logic       ringing, snoozing, buzz;

   int checks   = 0;
   int failures = 0;

   // Reference model: elapsed-seconds bookkeeping straight from the behavioural rules.
   logic [1:0] m_state;
   int         m_el, m_snz, m_hr, m_min;
   logic       m_beep;

   always #5 clk = ~clk;

   alarm_ctrl #(
      .RING_SEC   (RING),
      .SNOOZE_SEC (SNZ),
      .MAX_SNOOZE (MAXS)
   ) dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_sec_tick  (sec_tick),
      .i_cur_hr    (cur_hr),
      .i_cur_min   (cur_min),
      .i_cur_sec   (cur_sec),
      .i_alarm_on  (alarm_on),
      .i_set_en    (set_en),
      .i_hr_or_min (hr_or_min),
      .i_inc       (inc),
      .i_stop      (stop),
      .i_snooze    (snooze),
      .o_al_hr     (al_hr),
      .o_al_min    (al_min),
      .o_state     (state),
      .o_ringing   (ringing),
      .o_snoozing  (snoozing),
      .o_buzz      (buzz)
   );

   task automatic model_update();
      logic [1:0] ns;
      int         nel, nsnz, nhr, nmin;
      logic       nb, match;
      if (rst) begin
         m_state = S_OFF; m_el = 0; m_snz = 0; m_beep = 1'b0; m_hr = 0; m_min = 0;
         return;
      end
      nhr = m_hr; nmin = m_min;
      if (set_en && inc) begin
         if (hr_or_min) nmin = (m_min + 1) % 60;
         else           nhr  = (m_hr + 1) % 24;
      end
      match = sec_tick && !set_en && (int'(cur_hr) == m_hr) && (int'(cur_min) == m_min) &&
              (cur_sec == 6'd0);
      ns = m_state; nel = m_el; nsnz = m_snz; nb = m_beep;
      if (!alarm_on) ns = S_OFF;
      else begin
         case (m_state)
            S_OFF: ns = S_ARM;
            S_ARM: if (match) ns = S_RNG;
            S_RNG: begin
               if (stop || (snooze && m_snz >= MAXS)) ns = S_ARM;
               else if (snooze) begin
                  ns = S_SNZ; nsnz = m_snz + 1;
               end else if (sec_tick) begin
                  nel = m_el + 1; nb = !m_beep;
                  if (nel == RING) ns = S_ARM;
               end
            end
            default: begin
               if (stop) ns = S_ARM;
               else if (sec_tick) begin
                  nel = m_el + 1;
                  if (nel == SNZ) ns = S_RNG;
               end
            end
         endcase
      end
      if (ns != m_state) begin
         nel = 0;
         if (ns == S_RNG) nb = 1'b1;
      end
      if (ns == S_OFF || ns == S_ARM) begin
         nsnz = 0; nb = 1'b0;
      end
      if (ns == S_SNZ) nb = 1'b0;
      m_state = ns; m_el = nel; m_snz = nsnz; m_beep = nb; m_hr = nhr; m_min = nmin;
   endtask

   task automatic step();
      model_update();
      @(posedge clk);
      #1;
      sec_tick = 1'b0; inc = 1'b0; stop = 1'b0; snooze = 1'b0;
   endtask

   task automatic tick();
      sec_tick = 1'b1;
      step();
   endtask

   task automatic run_ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic ring_now();
      cur_hr = m_hr[4:0]; cur_min = m_min[5:0]; cur_sec = 6'd0;
      tick();
      cur_sec = 6'd1;
   endtask

   task automatic test_reset();
      rst = 1'b1; alarm_on = 1'b0; set_en = 1'b0; hr_or_min = 1'b0;
      sec_tick = 1'b0; inc = 1'b0; stop = 1'b0; snooze = 1'b0;
      cur_hr = '0; cur_min = '0; cur_sec = 6'd1;
      step(); step();
      rst = 1'b0;
      checks++;
      if ({state, ringing, snoozing, buzz, al_hr, al_min} !== 16'h0) begin
         failures++;
         $display("FAIL reset_outputs got state=%b r=%b s=%b buzz=%b al=%0d:%0d want all 0",
                  state, ringing, snoozing, buzz, al_hr, al_min);
      end
   endtask

   task automatic test_set_alarm();
      set_en = 1'b1; hr_or_min = 1'b0;
      for (int i = 0; i < 7; i++) begin inc = 1'b1; step(); end
      hr_or_min = 1'b1;
      for (int i = 0; i < 30; i++) begin inc = 1'b1; step(); end
      set_en = 1'b0;
      checks++;
      if (al_hr !== 5'd7 || al_min !== 6'd30) begin
         failures++;
         $display("FAIL set_0730 got %0d:%0d want 7:30", al_hr, al_min);
      end
      alarm_on = 1'b1; step();
      checks++;
      if (state !== S_ARM) begin
         failures++; $display("FAIL off_to_armed got %b want %b", state, S_ARM);
      end
      cur_hr = 5'd7; cur_min = 6'd29; cur_sec = 6'd59; tick();
      checks++;
      if (state !== S_ARM) begin
         failures++; $display("FAIL no_early_ring got %b want %b", state, S_ARM);
      end
      cur_min = 6'd30; cur_sec = 6'd0; tick(); cur_sec = 6'd1;
      checks++;
      if (state !== S_RNG || ringing !== 1'b1 || buzz !== 1'b1 || snoozing !== 1'b0) begin
         failures++;
         $display("FAIL ring_on_match got state=%b ringing=%b buzz=%b want 10/1/1",
                  state, ringing, buzz);
      end
      step();
      tick();
      checks++;
      if (buzz !== 1'b0) begin failures++; $display("FAIL buzz_toggle1 got %b want 0", buzz); end
      tick();
      checks++;
      if (buzz !== 1'b1) begin failures++; $display("FAIL buzz_toggle2 got %b want 1", buzz); end
   endtask

   task automatic test_ring_timeout();
      stop = 1'b1; step();
      checks++;
      if (state !== S_ARM || buzz !== 1'b0) begin
         failures++; $display("FAIL stop_ring got state=%b buzz=%b want 01/0", state, buzz);
      end
      ring_now();
      for (int k = 1; k <= RING; k++) begin
         if (k % 3 == 0) step();
         tick();
         checks++;
         if (k < RING) begin
            if (state !== S_RNG || buzz !== logic'(k % 2 == 0)) begin
               failures++;
               $display("FAIL ring_tick%0d got state=%b buzz=%b want 10/%0d",
                        k, state, buzz, (k % 2 == 0));
            end
         end else if (state !== S_ARM || buzz !== 1'b0 || ringing !== 1'b0) begin
            failures++;
            $display("FAIL ring_timeout got state=%b buzz=%b want 01/0", state, buzz);
         end
      end
   endtask

   task automatic test_snooze();
      ring_now();
      for (int p = 1; p <= 4; p++) begin
         snooze = 1'b1; step();
         checks++;
         if (p < 4) begin
            if (state !== S_SNZ || snoozing !== 1'b1 || buzz !== 1'b0) begin
               failures++;
               $display("FAIL snooze_entry%0d got state=%b buzz=%b want 11/0", p, state, buzz);
            end
            run_ticks(SNZ - 1);
            checks++;
            if (state !== S_SNZ) begin
               failures++; $display("FAIL snooze_hold%0d got %b want %b", p, state, S_SNZ);
            end
            tick();
            checks++;
            if (state !== S_RNG || buzz !== 1'b1) begin
               failures++;
               $display("FAIL rering%0d got state=%b buzz=%b want 10/1", p, state, buzz);
            end
         end else if (state !== S_ARM) begin
            failures++; $display("FAIL snooze_limit got %b want %b", state, S_ARM);
         end
      end
   endtask

   task automatic test_stop_snooze();
      ring_now();
      for (int i = 0; i < 2; i++) begin
         snooze = 1'b1; step(); run_ticks(SNZ);
      end
      stop = 1'b1; snooze = 1'b1; step();
      checks++;
      if (state !== S_ARM || buzz !== 1'b0) begin
         failures++; $display("FAIL stop_beats_snooze got state=%b buzz=%b want 01/0", state, buzz);
      end
      // Three fresh snoozes must be granted again after the count clears.
      ring_now();
      for (int i = 0; i < 3; i++) begin
         snooze = 1'b1; step();
         checks++;
         if (state !== S_SNZ) begin
            failures++; $display("FAIL cnt_cleared_snooze%0d got %b want %b", i, state, S_SNZ);
         end
         run_ticks(SNZ);
      end
      snooze = 1'b1; step();
      checks++;
      if (state !== S_ARM) begin
         failures++; $display("FAIL cnt_cleared_limit got %b want %b", state, S_ARM);
      end
   endtask

   task automatic test_off_paths();
      ring_now();
      snooze = 1'b1; step();
      alarm_on = 1'b0; stop = 1'b1; step();
      checks++;
      if (state !== S_OFF || snoozing !== 1'b0 || buzz !== 1'b0) begin
         failures++; $display("FAIL alarm_off_in_snooze got state=%b buzz=%b want 00/0", state, buzz);
      end
      alarm_on = 1'b1; step();
      ring_now();
      rst = 1'b1; step(); rst = 1'b0;
      checks++;
      if ({state, ringing, snoozing, buzz, al_hr, al_min} !== 16'h0) begin
         failures++;
         $display("FAIL rst_in_ringing got state=%b buzz=%b al=%0d:%0d want all 0",
                  state, buzz, al_hr, al_min);
      end
   endtask

   task automatic test_set_wrap();
      set_en = 1'b1; hr_or_min = 1'b1;
      for (int i = 0; i < 59; i++) begin inc = 1'b1; step(); end
      hr_or_min = 1'b0;
      for (int i = 0; i < 23; i++) begin inc = 1'b1; step(); end
      checks++;
      if (al_hr !== 5'd23 || al_min !== 6'd59) begin
         failures++; $display("FAIL set_2359 got %0d:%0d want 23:59", al_hr, al_min);
      end
      hr_or_min = 1'b1; inc = 1'b1; step();
      checks++;
      if (al_min !== 6'd0 || al_hr !== 5'd23) begin
         failures++; $display("FAIL min_wrap got %0d:%0d want 23:0", al_hr, al_min);
      end
      hr_or_min = 1'b0; inc = 1'b1; step();
      checks++;
      if (al_hr !== 5'd0) begin failures++; $display("FAIL hr_wrap got %0d want 0", al_hr); end
      alarm_on = 1'b1; step();
      cur_hr = 5'd0; cur_min = 6'd0; cur_sec = 6'd0; tick();
      checks++;
      if (state !== S_ARM || ringing !== 1'b0) begin
         failures++; $display("FAIL match_while_set got %b want %b", state, S_ARM);
      end
      set_en = 1'b0; tick();
      checks++;
      if (state !== S_RNG) begin
         failures++; $display("FAIL match_after_set got %b want %b", state, S_RNG);
      end
      stop = 1'b1; step();
   endtask

   task automatic test_random();
      for (int c = 0; c < 4000; c++) begin
         rst       = ($urandom_range(0, 199) == 0);
         alarm_on  = ($urandom_range(0, 59) != 0);
         set_en    = ($urandom_range(0, 9) == 0);
         hr_or_min = $urandom_range(0, 1);
         inc       = ($urandom_range(0, 2) == 0);
         stop      = ($urandom_range(0, 49) == 0);
         snooze    = ($urandom_range(0, 19) == 0);
         sec_tick  = $urandom_range(0, 1);
         cur_hr    = ($urandom_range(0, 3) != 0) ? m_hr[4:0] : 5'($urandom_range(0, 23));
         cur_min   = ($urandom_range(0, 3) != 0) ? m_min[5:0] : 6'($urandom_range(0, 59));
         cur_sec   = ($urandom_range(0, 1) != 0) ? 6'd0 : 6'($urandom_range(0, 59));
         step();
         checks++;
         if (state !== m_state || buzz !== m_beep || al_hr !== m_hr[4:0] ||
             al_min !== m_min[5:0] || ringing !== (m_state == S_RNG) ||
             snoozing !== (m_state == S_SNZ)) begin
            failures++;
            $display("FAIL random_c%0d got st=%b bz=%b al=%0d:%0d want st=%b bz=%b al=%0d:%0d",
                     c, state, buzz, al_hr, al_min, m_state, m_beep, m_hr, m_min);
         end
      end
      rst = 1'b0;
   endtask

   initial begin
      test_reset();
      test_set_alarm();
      test_ring_timeout();
      test_snooze();
      test_stop_snooze();
      test_off_paths();
      test_set_wrap();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
